// File: rtl/ram_dp_clr.sv
// Dual-port byte-lane RAM with a fill engine.
// After reset the engine writes INIT_VALUE to every entry. In IDLE a
// clr_start request starts a sweep that writes a caller-supplied value.
// While a sweep runs, both ports are locked out. Each port has a 1-cycle
// registered read, and RDW_MODE selects old-data or new-data reads.
// Port A wins when both ports write the same lane of the same address.
// WIDTH must be a multiple of BYTE_W, and 2**ADDR_BITS must be >= DEPTH.
module ram_dp_clr #(
   parameter int                WIDTH      = 64,
   parameter int                DEPTH      = 512,
   parameter int                ADDR_BITS  = 9,
   parameter int                BYTE_W     = 8,
   parameter logic [WIDTH-1:0]  INIT_VALUE = '1,
   parameter int                RDW_MODE   = 0,
   localparam int               NB         = WIDTH / BYTE_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_start,
   input  logic [WIDTH-1:0]     clr_value,
   output logic                 busy,
   output logic                 clr_done,
   input  logic                 en_a,
   input  logic [NB-1:0]        we_a,
   input  logic [ADDR_BITS-1:0] addr_a,
   input  logic [WIDTH-1:0]     w_data_a,
   output logic [WIDTH-1:0]     r_data_a,
   output logic                 r_valid_a,
   input  logic                 en_b,
   input  logic [NB-1:0]        we_b,
   input  logic [ADDR_BITS-1:0] addr_b,
   input  logic [WIDTH-1:0]     w_data_b,
   output logic [WIDTH-1:0]     r_data_b,
   output logic                 r_valid_b
);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);
   localparam logic [ADDR_BITS:0]   DEPTH_L  = (ADDR_BITS + 1)'(DEPTH);

   logic [1:0]           state_q,     state_d;
   logic [ADDR_BITS-1:0] idx_q,       idx_d;
   logic [WIDTH-1:0]     clr_val_q,   clr_val_d;
   logic                 clr_done_q,  clr_done_d;
   logic [WIDTH-1:0]     r_data_a_q,  r_data_a_d;
   logic [WIDTH-1:0]     r_data_b_q,  r_data_b_d;
   logic                 r_valid_a_q, r_valid_a_d;
   logic                 r_valid_b_q, r_valid_b_d;

   logic              idle;
   logic              acc_a, acc_b;
   logic              in_rng_a, in_rng_b;
   logic              same_addr;
   logic              fill_we;
   logic [WIDTH-1:0]  fill_data;
   logic [NB-1:0]     wr_a, wr_b;
   logic [WIDTH-1:0]  old_a, old_b, new_a, new_b;
   logic [WIDTH-1:0]  rd_a, rd_b;

   assign idle      = (state_q == ST_IDLE);
   assign acc_a     = idle & en_a;
   assign acc_b     = idle & en_b;
   assign in_rng_a  = ({1'b0, addr_a} < DEPTH_L);
   assign in_rng_b  = ({1'b0, addr_b} < DEPTH_L);
   assign same_addr = (addr_a == addr_b);
   // Out-of-range writes are dropped here, so no lane ever sees them.
   assign wr_a      = we_a & {NB{acc_a & in_rng_a}};
   assign wr_b      = we_b & {NB{acc_b & in_rng_b}};
   // Any non-IDLE state belongs to the fill engine, which owns the array.
   assign fill_we   = ~idle;
   assign fill_data = (state_q == ST_CLEAR) ? clr_val_q : INIT_VALUE;

   // Each byte lane has its own array, write logic and read-data mux.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [BYTE_W-1:0] lane_mem [DEPTH];
      logic [BYTE_W-1:0] wd_a, wd_b, fd;

      assign wd_a = w_data_a[gi*BYTE_W +: BYTE_W];
      assign wd_b = w_data_b[gi*BYTE_W +: BYTE_W];
      assign fd   = fill_data[gi*BYTE_W +: BYTE_W];

      // Lane write: the fill sweep, or the port writes. A is applied last, so it wins a collision.
      always_ff @(posedge clk) begin
         if (fill_we) begin
            lane_mem[idx_q] <= fd;
         end else begin
            if (wr_b[gi]) lane_mem[addr_b] <= wd_b;
            if (wr_a[gi]) lane_mem[addr_a] <= wd_a;
         end
      end

      assign old_a[gi*BYTE_W +: BYTE_W] = in_rng_a ? lane_mem[addr_a] : '0;
      assign old_b[gi*BYTE_W +: BYTE_W] = in_rng_b ? lane_mem[addr_b] : '0;

      // Post-cycle lane contents as seen by each port.
      assign new_a[gi*BYTE_W +: BYTE_W] = wr_a[gi]               ? wd_a :
                                          (wr_b[gi] && same_addr) ? wd_b :
                                          old_a[gi*BYTE_W +: BYTE_W];
      assign new_b[gi*BYTE_W +: BYTE_W] = (wr_a[gi] && same_addr) ? wd_a :
                                          wr_b[gi]                ? wd_b :
                                          old_b[gi*BYTE_W +: BYTE_W];
   end

   assign rd_a = (RDW_MODE == 1) ? new_a : old_a;
   assign rd_b = (RDW_MODE == 1) ? new_b : old_b;

   // Sweep sequencing: INIT/CLEAR step the index once per cycle, then return to IDLE.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      clr_val_d  = clr_val_q;
      clr_done_d = 1'b0;
      case (state_q)
         ST_INIT, ST_CLEAR: begin
            if (idx_q == LAST_IDX) begin
               state_d    = ST_IDLE;
               idx_d      = '0;
               clr_done_d = 1'b1;
            end else begin
               idx_d = idx_q + ADDR_BITS'(1);
            end
         end
         ST_IDLE: begin
            if (clr_start) begin
               state_d   = ST_CLEAR;
               idx_d     = '0;
               clr_val_d = clr_value;
            end
         end
         default: begin
            state_d = ST_INIT;
            idx_d   = '0;
         end
      endcase
   end

   // Read results: capture on an accepted access, otherwise hold the data and drop valid.
   always_comb begin
      r_valid_a_d = acc_a;
      r_valid_b_d = acc_b;
      r_data_a_d  = acc_a ? rd_a : r_data_a_q;
      r_data_b_d  = acc_b ? rd_b : r_data_b_q;
   end

   // Control and output flops. The array itself is deliberately not reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         idx_q       <= '0;
         clr_val_q   <= '0;
         clr_done_q  <= 1'b0;
         r_data_a_q  <= '0;
         r_data_b_q  <= '0;
         r_valid_a_q <= 1'b0;
         r_valid_b_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         clr_val_q   <= clr_val_d;
         clr_done_q  <= clr_done_d;
         r_data_a_q  <= r_data_a_d;
         r_data_b_q  <= r_data_b_d;
         r_valid_a_q <= r_valid_a_d;
         r_valid_b_q <= r_valid_b_d;
      end
   end

   assign busy      = ~idle;
   assign clr_done  = clr_done_q;
   assign r_data_a  = r_data_a_q;
   assign r_data_b  = r_data_b_q;
   assign r_valid_a = r_valid_a_q;
   assign r_valid_b = r_valid_b_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr. Two instances share every input: one reads old data
// and one reads new data on a read-during-write. DEPTH is below 2**ADDR_BITS,
// so the bench can reach out-of-range addresses. A word-level memory model
// predicts busy, clr_done and both read ports every cycle.
module tb_ram_dp_clr;
   localparam int W  = 64;
   localparam int D  = 500;
   localparam int AB = 9;
   localparam int BW = 8;
   localparam int NB = W / BW;
   localparam logic [W-1:0] INIT_V = '1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          clr_start;
   logic [W-1:0]  clr_value;
   logic          en_a, en_b;
   logic [NB-1:0] we_a, we_b;
   logic [AB-1:0] addr_a, addr_b;
   logic [W-1:0]  w_data_a, w_data_b;

   logic [1:0]        busy_o, done_o, va_o, vb_o;
   logic [1:0][W-1:0] rda_o, rdb_o;

   ram_dp_clr #(.WIDTH(W), .DEPTH(D), .ADDR_BITS(AB), .BYTE_W(BW),
                .INIT_VALUE(INIT_V), .RDW_MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_value(clr_value),
      .busy(busy_o[0]), .clr_done(done_o[0]),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .w_data_a(w_data_a),
      .r_data_a(rda_o[0]), .r_valid_a(va_o[0]),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .w_data_b(w_data_b),
      .r_data_b(rdb_o[0]), .r_valid_b(vb_o[0]));

   ram_dp_clr #(.WIDTH(W), .DEPTH(D), .ADDR_BITS(AB), .BYTE_W(BW),
                .INIT_VALUE(INIT_V), .RDW_MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_value(clr_value),
      .busy(busy_o[1]), .clr_done(done_o[1]),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .w_data_a(w_data_a),
      .r_data_a(rda_o[1]), .r_valid_a(va_o[1]),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .w_data_b(w_data_b),
      .r_data_b(rdb_o[1]), .r_valid_b(vb_o[1]));

   // Reference model state
   logic [W-1:0] mem_m [D];
   bit           m_busy;
   int           m_idx;
   logic [W-1:0] m_fill;
   logic [W-1:0] e_rda [2];
   logic [W-1:0] e_rdb [2];
   bit           e_va, e_vb, e_done;
   int           vecs = 0;
   int           errs = 0;

   function automatic logic [W-1:0] mask_of(input logic [NB-1:0] we);
      logic [W-1:0] m;
      for (int i = 0; i < NB; i++) m[i*BW +: BW] = {BW{we[i]}};
      return m;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge, using the inputs currently driven.
   task automatic model_step();
      logic [W-1:0] ma, mb, old_a, old_b, new_a, new_b;
      bit ina, inb;
      if (m_busy) begin
         mem_m[m_idx] = m_fill;
         m_idx++;
         e_va = 0; e_vb = 0;
         e_done = (m_idx == D);
         if (e_done) m_busy = 0;
      end else begin
         ina = (int'(addr_a) < D);
         inb = (int'(addr_b) < D);
         ma = (en_a && ina) ? mask_of(we_a) : '0;
         mb = (en_b && inb) ? mask_of(we_b) : '0;
         old_a = ina ? mem_m[addr_a] : '0;
         old_b = inb ? mem_m[addr_b] : '0;
         if (mb != '0) mem_m[addr_b] = (mem_m[addr_b] & ~mb) | (w_data_b & mb);
         if (ma != '0) mem_m[addr_a] = (mem_m[addr_a] & ~ma) | (w_data_a & ma);
         new_a = ina ? mem_m[addr_a] : '0;
         new_b = inb ? mem_m[addr_b] : '0;
         if (en_a) begin e_rda[0] = old_a; e_rda[1] = new_a; end
         if (en_b) begin e_rdb[0] = old_b; e_rdb[1] = new_b; end
         e_va = en_a; e_vb = en_b; e_done = 0;
         if (clr_start) begin m_busy = 1; m_idx = 0; m_fill = clr_value; end
      end
   endtask

   task automatic check_outputs(input string ph);
      for (int k = 0; k < 2; k++) begin
         chk({ph, " busy"},      W'(busy_o[k]), W'(m_busy));
         chk({ph, " clr_done"},  W'(done_o[k]), W'(e_done));
         chk({ph, " r_valid_a"}, W'(va_o[k]),   W'(e_va));
         chk({ph, " r_valid_b"}, W'(vb_o[k]),   W'(e_vb));
         chk({ph, " r_data_a"},  rda_o[k],      e_rda[k]);
         chk({ph, " r_data_b"},  rdb_o[k],      e_rdb[k]);
      end
   endtask

   task automatic cyc(input string ph);
      model_step();
      @(posedge clk); #1;
      check_outputs(ph);
   endtask

   task automatic idle_in();
      clr_start = 0; en_a = 0; en_b = 0; we_a = '0; we_b = '0;
   endtask

   task automatic rand_access();
      en_a = ($urandom_range(0, 3) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      we_a = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
      we_b = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
      addr_a = ($urandom_range(0, 15) == 0) ? AB'($urandom_range(D, 511)) : AB'($urandom_range(0, 15));
      addr_b = ($urandom_range(0, 15) == 0) ? AB'($urandom_range(D, 511)) : AB'($urandom_range(0, 15));
      w_data_a = {$urandom, $urandom};
      w_data_b = {$urandom, $urandom};
   endtask

   // Hold reset for two edges, check the reset values, then release at a falling edge.
   task automatic do_reset();
      rst_n = 0;
      m_busy = 1; m_idx = 0; m_fill = INIT_V;
      for (int k = 0; k < 2; k++) begin e_rda[k] = '0; e_rdb[k] = '0; end
      e_va = 0; e_vb = 0; e_done = 0;
      #1;
      check_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset_hold");
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic wait_sweep(input string ph);
      for (int i = 0; i < D; i++) cyc(ph);
   endtask

   task automatic read_all(input string ph, input logic [W-1:0] val);
      for (int i = 0; i < D / 2; i++) begin
         en_a = 1; we_a = '0; addr_a = AB'(2 * i);
         en_b = 1; we_b = '0; addr_b = AB'(2 * i + 1);
         cyc(ph);
         chk({ph, " fill_a"}, rda_o[0], val);
         chk({ph, " fill_b"}, rdb_o[1], val);
      end
      idle_in();
   endtask

   initial begin
      rst_n = 1;
      idle_in();
      clr_value = '0; addr_a = '0; addr_b = '0; w_data_a = '0; w_data_b = '0;
      #2;
      do_reset();

      // Init sweep, then first reads of both ends of the array
      wait_sweep("init");
      en_a = 1; addr_a = AB'(0); en_b = 1; addr_b = AB'(D - 1);
      cyc("init_rd");
      chk("init_rd_a", rda_o[0], INIT_V);
      chk("init_rd_b", rdb_o[0], INIT_V);
      addr_a = AB'(D - 1); addr_b = AB'(0);
      cyc("init_rd2");
      idle_in();
      cyc("hold");

      // Byte-lane write at addr 5
      en_a = 1; we_a = 8'hFF; addr_a = AB'(5); w_data_a = 64'h1122334455667788;
      cyc("wr5_full");
      we_a = 8'h01; w_data_a = 64'h00000000000000AA;
      cyc("wr5_lane0");
      we_a = '0;
      cyc("rd5");
      chk("rd5_value", rda_o[0], 64'h11223344556677AA);
      idle_in();

      // Same-address collisions at addr 9
      en_a = 1; en_b = 1; addr_a = AB'(9); addr_b = AB'(9);
      we_a = 8'hFF; we_b = 8'hFF; w_data_a = 64'h1; w_data_b = 64'h2;
      cyc("coll_full");
      we_a = '0; we_b = '0;
      cyc("coll_rd");
      chk("coll_a_wins", rda_o[0], 64'h1);
      we_a = 8'h01; w_data_a = 64'hDEADBEEF00000033;
      we_b = 8'h80; w_data_b = 64'h44ABCDEF12345678;
      cyc("coll_lanes");
      we_a = '0; we_b = '0;
      cyc("coll_lanes_rd");
      chk("coll_lanes_val", rdb_o[0], 64'h4400000000000033);
      idle_in();

      // Read-during-write at addr 3
      en_a = 1; we_a = 8'hFF; addr_a = AB'(3); w_data_a = 64'h5;
      cyc("rdw_prep");
      w_data_a = 64'h9; en_b = 1; we_b = '0; addr_b = AB'(3);
      cyc("rdw");
      chk("rdw_mode0", rdb_o[0], 64'h5);
      chk("rdw_mode1", rdb_o[1], 64'h9);
      idle_in();

      // Out-of-range address: write dropped, read returns 0 with valid
      en_a = 1; we_a = 8'hFF; addr_a = AB'(505); w_data_a = 64'hCAFE;
      en_b = 1; we_b = '0; addr_b = AB'(505);
      cyc("oor");
      chk("oor_rd_b", rdb_o[1], 64'h0);
      chk("oor_valid_b", W'(vb_o[0]), W'(1'b1));
      idle_in();

      // Random two-port traffic over a small address window
      for (int i = 0; i < 300; i++) begin
         rand_access();
         cyc("rand");
      end
      idle_in();

      // Clear to 0, with port traffic in the start cycle and during the sweep
      rand_access();
      clr_start = 1; clr_value = '0;
      cyc("clr_start");
      for (int i = 0; i < D; i++) begin
         rand_access();
         clr_start = (i == 200);
         clr_value = {$urandom, $urandom};
         cyc("clr_sweep");
      end
      idle_in();
      read_all("clr_rd", '0);

      // Reset during a clear: the refill uses INIT_VALUE
      clr_start = 1; clr_value = '0;
      cyc("clr2_start");
      clr_start = 0;
      for (int i = 0; i < 100; i++) cyc("clr2_sweep");
      do_reset();
      wait_sweep("reinit");
      read_all("reinit_rd", INIT_V);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
